shutter_dir_ctrl: RTL and testbench

Command stage directly upstream of the shutter motor controller; produces the level-coded `direct` input that the motor controller edge-detects.
- Sources: two raw push buttons (up/down) and, optionally, an 8-bit light level with hysteresis thresholds.
- Debounces the buttons, arbitrates requests, and enforces a minimum hold-off between direction changes.
- The hold-off exceeds the motor controller's drive window, so a second change is never issued mid-move.

---
 rtl/shutter_pkg.sv | 15 +
 rtl/btn_debounce.sv | 37 +++
 rtl/shutter_dir_ctrl.sv | 76 +++++++
 tb/tb_shutter_dir_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shutter_pkg.sv
// shutter_pkg: direction constants, FSM encoding and request type shared by the shutter blocks
package shutter_pkg;
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_APPLY   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;
  typedef struct packed {
    logic v;
    logic d;
  } req_t;
  function automatic req_t mk_req(input logic v, input logic d);
    mk_req = '{v: v, d: d};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, accepts a level stable for DEBOUNCE_MS ticks, pulses on press
module btn_debounce
  import shutter_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_50,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);
  localparam int W = $clog2(DEBOUNCE_MS) + 1;
  localparam logic [W-1:0] TERM = W'(DEBOUNCE_MS);
  logic [1:0] sync;
  logic acc;
  logic [W-1:0] cnt;
  logic hit;
  assign hit = cnt == TERM;
  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) sync <= '0;
    else sync <= {sync[0], btn};
  // stability counter: runs on ticks while the input disagrees, saturates at the terminal count
  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (sync[1] == acc) ? '0 : (tick && !hit) ? cnt + 1'b1 : cnt;
  // accepted level and rising-edge press pulse
  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) begin
      acc   <= 1'b0;
      press <= 1'b0;
    end else begin
      acc   <= hit ? sync[1] : acc;
      press <= hit & sync[1] & ~acc;
    end
endmodule

// File: rtl/shutter_dir_ctrl.sv
// shutter_dir_ctrl: button/light arbitration with direction hold-off; SHUTTER_AUTO_EN enables light decode
module shutter_dir_ctrl
  import shutter_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLDOFF_MS  = 500,
  parameter logic [7:0] LIGHT_HI = 8'hC0,
  parameter logic [7:0] LIGHT_LO = 8'h40
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  input  logic [7:0] light_level,
  input  logic       light_valid,
  output logic       direct,
  output logic       dir_changed,
  output logic       busy
);
  localparam int TW = $clog2(CLK_DIV) + 1;
  localparam int HW = $clog2(HOLDOFF_MS) + 1;
  localparam logic [TW-1:0] TTERM = TW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HTERM = HW'(HOLDOFF_MS);
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic tick, press_up, press_dn, man, h_end, go;
  logic [1:0] state, state_n;
  req_t rq, req_q, pend, pend_n;
  assign tick = tcnt == TTERM;
  // free-running 1 ms tick divider
  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_up (
    .clk_50(clk_50), .reset(reset), .tick(tick), .btn(btn_up), .press(press_up)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_dn (
    .clk_50(clk_50), .reset(reset), .tick(tick), .btn(btn_down), .press(press_dn)
  );
  assign man = press_up ^ press_dn;
`ifdef SHUTTER_AUTO_EN
  logic lo, hi;
  assign hi = light_level >= LIGHT_HI;
  assign lo = light_level <= LIGHT_LO;
  assign rq = man ? mk_req(1'b1, press_up) : mk_req(auto_en & light_valid & (hi | lo), lo);
`else
  logic unused_auto;
  assign unused_auto = ^{auto_en, light_level, light_valid, LIGHT_HI, LIGHT_LO};
  assign rq = mk_req(man, press_up);
`endif
  assign h_end       = hcnt == HTERM;
  assign pend_n      = req_q.v ? mk_req(req_q.d != direct, req_q.d) : pend;
  assign go          = state == S_IDLE ? req_q.v && req_q.d != direct :
                       state == S_HOLDOFF ? h_end && pend_n.v : 1'b0;
  assign state_n     = go ? S_APPLY : state == S_APPLY ? S_HOLDOFF :
                       (state == S_HOLDOFF && !h_end) ? S_HOLDOFF : S_IDLE;
  assign dir_changed = state == S_APPLY;
  assign busy        = state == S_HOLDOFF;
  // request decode register, FSM, direction, hold-off counter and last-wins pending request
  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) begin
      req_q  <= '0;
      state  <= S_IDLE;
      direct <= DOWN;
      hcnt   <= '0;
      pend   <= '0;
    end else begin
      req_q  <= rq;
      state  <= state_n;
      direct <= go ? ~direct : direct;
      hcnt   <= state == S_APPLY ? '0 : (busy && tick && !h_end) ? hcnt + 1'b1 : hcnt;
      pend   <= (busy && !h_end) ? pend_n : '0;
    end
endmodule

// File: tb/tb_shutter_dir_ctrl.sv
// tb_shutter_dir_ctrl: directed tick-aligned stimulus with hand-timed expectations
module tb_shutter_dir_ctrl;
  logic clk_50 = 1'b0, reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, auto_en = 1'b0, light_valid = 1'b0;
  logic [7:0] light_level = 8'h00;
  logic direct, dir_changed, busy;
  int nchk = 0, nfail = 0, nchg = 0, bcnt = 0, ecount = 0;

  shutter_dir_ctrl #(.CLK_DIV(10), .DEBOUNCE_MS(2), .HOLDOFF_MS(5)) dut (
    .clk_50(clk_50), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .auto_en(auto_en), .light_level(light_level), .light_valid(light_valid),
    .direct(direct), .dir_changed(dir_changed), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  // edge count since reset release: ticks land on edges that are multiples of 10
  always @(posedge clk_50 or negedge reset)
    if (!reset) ecount <= 0;
    else ecount <= ecount + 1;

  always @(posedge clk_50) begin
    if (dir_changed) nchg <= nchg + 1;
    if (busy) bcnt <= bcnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (ecount < t) @(negedge clk_50);
  endtask

  task automatic strobe(input logic [7:0] v);
    light_level = v;
    light_valid = 1'b1;
    @(negedge clk_50);
    light_valid = 1'b0;
  endtask

  // from direct=1 idle: down, pending up re-enters hold-off at direct=1, then down (+ up if cancel)
  task automatic chain(input bit cancel);
    int b = ecount;
    int n0 = nchg;
    btn_down = 1'b1;
    wait_to(b + 10); btn_up = 1'b1;
    wait_to(b + 30); btn_down = 1'b0;
    wait_to(b + 40); btn_up = 1'b0;
    wait_to(b + 50);
    chk("chain_dir_a", direct, 0);
    chk("chain_busy_a", busy, 1);
    wait_to(b + 60); btn_down = 1'b1;
    if (cancel) begin
      wait_to(b + 70); btn_up = 1'b1;
    end
    wait_to(b + 100);
    chk("chain_dir_b", direct, 1);
    chk("chain_busy_b", busy, 1);
    btn_down = 1'b0;
    wait_to(b + 110); btn_up = 1'b0;
    wait_to(b + 140);
    if (cancel) begin
      chk("cancel_dir", direct, 1);
      chk("cancel_busy", busy, 0);
      chk("cancel_nchg", nchg, n0 + 2);
    end else begin
      chk("pend_dir", direct, 0);
      chk("pend_busy", busy, 1);
      chk("pend_nchg", nchg, n0 + 3);
      wait_to(b + 180);
      chk("pend_idle_busy", busy, 0);
      chk("pend_idle_dir", direct, 0);
    end
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk_50);
    chk("rst_direct", direct, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dchg", dir_changed, 0);
    reset = 1'b1;
    btn_up = 1'b1;
    wait_to(23);
    chk("t1_dchg_pulse", dir_changed, 1);
    wait_to(40);
    chk("t1_direct", direct, 1);
    chk("t1_busy", busy, 1);
    chk("t1_nchg", nchg, 1);
    btn_up = 1'b0;
    wait_to(80);
    chk("t1_busy_end", busy, 0);
    chk("t1_direct_end", direct, 1);
    chk("t1_busy_cycles", bcnt, 47);
    chk("t1_nchg_end", nchg, 1);
    btn_down = 1'b1;
    wait_to(92); btn_down = 1'b0;
    wait_to(130);
    chk("t2_direct", direct, 1);
    chk("t2_nchg", nchg, 1);
    chk("t2_busy", busy, 0);
    chain(1'b1);
    chain(1'b0);
`ifdef SHUTTER_AUTO_EN
    reset = 1'b0;
    @(negedge clk_50);
    chk("t5_rst_direct", direct, 0);
    reset = 1'b1;
    auto_en = 1'b1;
    n0 = nchg;
    wait_to(2); strobe(8'hC0);
    wait_to(6);
    chk("t5_hi_same", direct, 0);
    chk("t5_hi_nchg", nchg, n0);
    wait_to(10); strobe(8'h40);
    wait_to(12);
    chk("t5_lo_dchg", dir_changed, 1);
    chk("t5_lo_dir", direct, 1);
    wait_to(30);
    chk("t5_lo_busy", busy, 1);
    wait_to(65);
    chk("t5_hold_end", busy, 0);
    strobe(8'h80);
    wait_to(70);
    chk("t5_mid_dir", direct, 1);
    chk("t5_mid_busy", busy, 0);
    strobe(8'hC0);
    wait_to(75);
    chk("t5_hi_dir", direct, 0);
    chk("t5_hi_busy", busy, 1);
    auto_en = 1'b0;
`else
    auto_en = 1'b1;
    strobe(8'h40);
    repeat (5) @(negedge clk_50);
    chk("noauto_dir", direct, 0);
    chk("noauto_busy", busy, 0);
    auto_en = 1'b0;
`endif
    reset = 1'b0;
    @(negedge clk_50);
    chk("t6_rst_direct", direct, 0);
    chk("t6_rst_busy", busy, 0);
    reset = 1'b1;
    n0 = nchg;
    btn_up = 1'b1;
    btn_down = 1'b1;
    wait_to(40);
    chk("t6_both_dir", direct, 0);
    chk("t6_both_nchg", nchg, n0);
    btn_up = 1'b0;
    btn_down = 1'b0;
    wait_to(70); btn_up = 1'b1;
    wait_to(80); btn_down = 1'b1;
    wait_to(100);
    chk("t6_hold_dir", direct, 1);
    chk("t6_hold_busy", busy, 1);
    wait_to(110);
    reset = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    #1;
    chk("t6_async_dir", direct, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_dchg", dir_changed, 0);
    @(negedge clk_50);
    reset = 1'b1;
    repeat (80) @(negedge clk_50);
    chk("t6_lost_dir", direct, 0);
    chk("t6_lost_busy", busy, 0);
    chk("t6_lost_nchg", nchg, n0 + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
